// File: rtl/channels_supervisor.sv
// channels_supervisor
//   Configuration and link-safety controller for the RC channel decoder.
//   - Shadow registers for channel route, polarity and deadzone; a commit
//     copies them to the active configuration when the FSM is DISARMED and
//     the route is a permutation. A write in the commit cycle is included.
//   - Per-channel watchdog counters clocked by a timebase tick and cleared
//     by capture-done pulses. A saturated counter flags the channel as lost.
//   - Frame detection and an arm/failsafe state machine that gates vehicle
//     drive.
//
// Optional feature (macro CHSUP_AUTO_REARM_EN):
//   defined   : FAILSAFE returns to ARMING by itself once no channel is lost.
//   undefined : FAILSAFE is left only through i_disarm.
//
// Ports:
//   i_clk, i_rst         clock, synchronous active-high reset
//   i_wr_en/addr/data    shadow write (0=route, 1=polarity, 2=deadzone, 3=none)
//   i_commit             shadow -> active copy request
//   i_arm, i_disarm      arm / disarm request pulses
//   i_timebase           watchdog timebase tick
//   i_capture_done       per-channel capture-done pulses
//   o_chan_route         active route, entry k in bits [k*W +: W]
//   o_polarity           active polarity
//   o_deadzone           active deadzone
//   o_cfg_err            one-cycle pulse after a rejected commit
//   o_lost               per-channel lost flags
//   o_armed, o_failsafe  decoded FSM state
module channels_supervisor #(
  parameter int K_NCHAN        = 4,
  parameter int K_RES          = 10,
  parameter int K_TIMEOUT      = 50,
  parameter int K_ARM_FRAMES   = 8,
  parameter int K_DEADZONE_RST = 16
) (
  input  logic                                 i_clk,
  input  logic                                 i_rst,
  input  logic                                 i_wr_en,
  input  logic [1:0]                           i_wr_addr,
  input  logic [15:0]                          i_wr_data,
  input  logic                                 i_commit,
  input  logic                                 i_arm,
  input  logic                                 i_disarm,
  input  logic                                 i_timebase,
  input  logic [K_NCHAN-1:0]                   i_capture_done,
  output logic [K_NCHAN*$clog2(K_NCHAN)-1:0]   o_chan_route,
  output logic [K_NCHAN-1:0]                   o_polarity,
  output logic [K_RES-1:0]                     o_deadzone,
  output logic                                 o_cfg_err,
  output logic [K_NCHAN-1:0]                   o_lost,
  output logic                                 o_armed,
  output logic                                 o_failsafe
);

  localparam int W  = $clog2(K_NCHAN);
  localparam int RW = K_NCHAN * W;
  localparam int CW = $clog2(K_TIMEOUT + 1);
  localparam int FW = $clog2(K_ARM_FRAMES + 1);

  typedef enum logic [1:0] {
    ST_DISARMED = 2'd0,
    ST_ARMING   = 2'd1,
    ST_ARMED    = 2'd2,
    ST_FAILSAFE = 2'd3
  } state_t;

  state_t state_reg, state_next;
  logic [FW-1:0] frame_cnt_reg, frame_cnt_next;

  logic [RW-1:0]      shadow_route_reg, act_route_reg, route_eff, route_rst;
  logic [K_NCHAN-1:0] shadow_pol_reg, act_pol_reg, pol_eff;
  logic [K_RES-1:0]   shadow_dz_reg, act_dz_reg, dz_eff;
  logic               cfg_err_reg;
  logic [K_NCHAN-1:0] seen_reg, seen_next;
  logic [K_NCHAN-1:0] idx_present;
  logic [K_NCHAN-1:0] lost_vec;
  logic               route_valid, commit_ok, frame_tick;

  // Only the low bits of the write bus are meaningful for each register.
  logic wr_data_unused;
  assign wr_data_unused = ^i_wr_data;

  // Identity route used as reset value.
  for (genvar gi = 0; gi < K_NCHAN; gi++) begin : g_route_rst
    assign route_rst[gi*W +: W] = W'(gi);
  end

  // Shadow values seen by a commit, including a write in the same cycle.
  assign route_eff = (i_wr_en && i_wr_addr == 2'd0) ? i_wr_data[RW-1:0]      : shadow_route_reg;
  assign pol_eff   = (i_wr_en && i_wr_addr == 2'd1) ? i_wr_data[K_NCHAN-1:0] : shadow_pol_reg;
  assign dz_eff    = (i_wr_en && i_wr_addr == 2'd2) ? i_wr_data[K_RES-1:0]   : shadow_dz_reg;

  // With K_NCHAN entries, every index being present at least once implies
  // each appears exactly once and no entry is out of range.
  for (genvar gi = 0; gi < K_NCHAN; gi++) begin : g_perm
    logic [K_NCHAN-1:0] hit;
    for (genvar gk = 0; gk < K_NCHAN; gk++) begin : g_hit
      assign hit[gk] = (route_eff[gk*W +: W] == W'(gi));
    end
    assign idx_present[gi] = |hit;
  end
  assign route_valid = &idx_present;
  assign commit_ok   = i_commit && (state_reg == ST_DISARMED) && route_valid;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      shadow_route_reg <= route_rst;
      shadow_pol_reg   <= '0;
      shadow_dz_reg    <= K_RES'(K_DEADZONE_RST);
      act_route_reg    <= route_rst;
      act_pol_reg      <= '0;
      act_dz_reg       <= K_RES'(K_DEADZONE_RST);
      cfg_err_reg      <= 1'b0;
    end else begin
      if (i_wr_en) begin
        case (i_wr_addr)
          2'd0:    shadow_route_reg <= i_wr_data[RW-1:0];
          2'd1:    shadow_pol_reg   <= i_wr_data[K_NCHAN-1:0];
          2'd2:    shadow_dz_reg    <= i_wr_data[K_RES-1:0];
          default: ;
        endcase
      end
      if (commit_ok) begin
        act_route_reg <= route_eff;
        act_pol_reg   <= pol_eff;
        act_dz_reg    <= dz_eff;
      end
      cfg_err_reg <= i_commit && !commit_ok;
    end
  end

  // Per-channel watchdog. The lost flag is registered from the next counter
  // value so it always matches the counter register.
  for (genvar gi = 0; gi < K_NCHAN; gi++) begin : g_wd
    logic [CW-1:0] wd_cnt_reg, wd_cnt_next;
    logic          lost_reg;

    always_comb begin
      wd_cnt_next = wd_cnt_reg;
      if (i_capture_done[gi])
        wd_cnt_next = '0;
      else if (i_timebase && wd_cnt_reg != CW'(K_TIMEOUT))
        wd_cnt_next = wd_cnt_reg + CW'(1);
    end

    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        wd_cnt_reg <= CW'(K_TIMEOUT);
        lost_reg   <= 1'b1;
      end else begin
        wd_cnt_reg <= wd_cnt_next;
        lost_reg   <= (wd_cnt_next == CW'(K_TIMEOUT));
      end
    end

    assign lost_vec[gi] = lost_reg;
  end

  // A frame completes when every channel has reported; the completing
  // cycle's pulses belong to that frame, so seen restarts empty.
  assign frame_tick = &(seen_reg | i_capture_done);
  assign seen_next  = frame_tick ? '0 : (seen_reg | i_capture_done);

  always_comb begin
    state_next     = state_reg;
    frame_cnt_next = frame_cnt_reg;
    case (state_reg)
      ST_DISARMED: begin
        if (i_arm) begin
          state_next     = ST_ARMING;
          frame_cnt_next = '0;
        end
      end
      ST_ARMING: begin
        if (|lost_vec) begin
          state_next = ST_DISARMED;
        end else if (frame_tick) begin
          if (frame_cnt_reg == FW'(K_ARM_FRAMES - 1))
            state_next = ST_ARMED;
          frame_cnt_next = frame_cnt_reg + FW'(1);
        end
      end
      ST_ARMED: begin
        if (|lost_vec)
          state_next = ST_FAILSAFE;
      end
      ST_FAILSAFE: begin
`ifdef CHSUP_AUTO_REARM_EN
        if (lost_vec == '0) begin
          state_next     = ST_ARMING;
          frame_cnt_next = '0;
        end
`else
        state_next = ST_FAILSAFE;
`endif
      end
      default: state_next = ST_DISARMED;
    endcase
    // Disarm overrides every other transition.
    if (i_disarm)
      state_next = ST_DISARMED;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg     <= ST_DISARMED;
      frame_cnt_reg <= '0;
      seen_reg      <= '0;
    end else begin
      state_reg     <= state_next;
      frame_cnt_reg <= frame_cnt_next;
      seen_reg      <= seen_next;
    end
  end

  assign o_chan_route = act_route_reg;
  assign o_polarity   = act_pol_reg;
  assign o_deadzone   = act_dz_reg;
  assign o_cfg_err    = cfg_err_reg;
  assign o_lost       = lost_vec;
  assign o_armed      = (state_reg == ST_ARMED);
  assign o_failsafe   = (state_reg != ST_ARMED);

endmodule

// File: doc/channels_supervisor.md
Name: channels_supervisor

Overview:
Configuration and link-safety controller for the RC channel decoder.
- Holds the decoder configuration (channel route, polarity, deadzone) in shadow registers and commits it atomically after validation.
- Watches the per-channel capture-done pulses against a timebase watchdog.
- Sequences an arm/failsafe state machine that gates whether the decoded power/steer outputs may drive the vehicle.

Parameters:
K_NCHAN, 4, number of RC channels; K_NCHAN*$clog2(K_NCHAN) <= 16.
K_RES, 10, decoder resolution, width of deadzone; <= 16.
K_TIMEOUT, 50, timebase ticks without capture before a channel is declared lost.
K_ARM_FRAMES, 8, consecutive complete frames required to arm.
K_DEADZONE_RST, 16, deadzone reset value.

Ports:
i_clk  in  1  clock
i_rst  in  1  reset, synchronous, active-high
i_wr_en  in  1  shadow register write strobe
i_wr_addr  in  2  0=route, 1=polarity, 2=deadzone, 3=reserved (write ignored)
i_wr_data  in  16  write data, LSB-aligned; unused MSBs ignored
i_commit  in  1  request copy of shadow registers to active configuration
i_arm  in  1  arm request pulse
i_disarm  in  1  disarm request pulse
i_timebase  in  1  timebase tick, one-cycle pulse
i_capture_done  in  K_NCHAN  per-channel capture-done pulses from the decoder
o_chan_route  out  K_NCHAN x $clog2(K_NCHAN)  active route; entry k in bits [k*W+W-1:k*W]
o_polarity  out  K_NCHAN  active polarity
o_deadzone  out  K_RES  active deadzone
o_cfg_err  out  1  one-cycle pulse: commit rejected
o_lost  out  K_NCHAN  per-channel lost flag
o_armed  out  1  state == ARMED
o_failsafe  out  1  state != ARMED

Behaviour:
Reset values:
- Shadow and active route are identity (route[k]=k; 0xE4 for K_NCHAN=4). Polarity is 0. Deadzone is K_DEADZONE_RST.
- State is DISARMED; o_armed=0, o_failsafe=1, o_cfg_err=0.
- Watchdog counters are set to K_TIMEOUT, so o_lost is all ones.

Shadow writes:
- A write lands on the clock edge where i_wr_en is high. Addr 3 is a no-op.

Commit:
- Evaluated on the clock edge where i_commit is high.
- The shadow value used includes a write in the same cycle (bypass).
- Accepted only if state == DISARMED and the route is a permutation (every index 0..K_NCHAN-1 appears exactly once).
- Accepted: active outputs update the next cycle.
- Rejected (state not DISARMED, or invalid route): active outputs unchanged and o_cfg_err pulses high the next cycle. The shadow registers keep their content.

Watchdog, per channel i:
- Counter saturates at K_TIMEOUT and increments on i_timebase.
- i_capture_done[i] clears the counter to 0. If both occur in the same cycle, the clear wins.
- o_lost[i] = (counter == K_TIMEOUT), registered.

Frame detection:
- A seen[K_NCHAN] register sets bit i on i_capture_done[i].
- When (seen | i_capture_done) is all ones, a frame_tick is generated that cycle and seen clears to 0. The current cycle's pulses are consumed by that frame.

FSM (registered state; o_armed/o_failsafe are decoded directly from the state register):
- DISARMED: i_arm -> ARMING, frame counter cleared.
- ARMING: frame_tick increments the frame counter. Reaching K_ARM_FRAMES with no o_lost bit set -> ARMED. Any o_lost bit set -> DISARMED.
- ARMED: any o_lost bit set -> FAILSAFE.
- FAILSAFE: exit conditions depend on the optional feature below.
- i_disarm in any state -> DISARMED, and has priority over i_arm and over all other transitions in the same cycle.
- i_arm outside DISARMED is ignored.
- o_failsafe goes high on the cycle after o_lost first asserts.

Reset asserted mid-operation returns everything to the reset values on the next edge, including the active configuration.

Optional Feature:
Macro CHSUP_AUTO_REARM_EN.
- Defined: in FAILSAFE, when o_lost is all zero -> ARMING with the frame counter cleared. Re-arming then needs K_ARM_FRAMES good frames.
- Undefined: FAILSAFE is left only via i_disarm -> DISARMED, followed by an explicit i_arm.

Test Plan:
1. Release i_rst, no captures -> o_chan_route=0xE4, o_polarity=0, o_deadzone=16, o_lost=4'hF, o_failsafe=1, o_armed=0.
2. In DISARMED, write addr0=0x1B with i_commit in the same cycle -> o_chan_route=0x1B next cycle, no o_cfg_err. Then write 0x00 and commit -> o_cfg_err pulses once, route stays 0x1B.
3. Drive captures on all 4 channels every 20 timebase ticks, pulse i_arm -> o_armed=1 one cycle after the 8th frame_tick; o_failsafe=0.
4. While ARMED, stop channel 2 -> o_lost[2]=1 on the 50th tick without capture, o_failsafe=1 the next cycle. Resume channel 2 -> with the macro, o_armed returns after 8 frames; without it, stays FAILSAFE until i_disarm then i_arm.
5. While ARMED, commit a valid route -> o_cfg_err pulse, route unchanged. Pulse i_disarm and i_arm in the same cycle -> DISARMED.
6. Channel counter at 49 with i_timebase and i_capture_done in the same cycle -> counter 0, o_lost stays 0. Also: i_rst while ARMED -> all reset values on the next cycle.
